// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_writeback
//  Purpose  : Writer-side front end of the integer register file. Arbitrates
//             the single-cycle ALU result path (port A) and the long-latency
//             load/multiply result path (port B) onto the single register
//             file write port. It also keeps a pending-write scoreboard, so the
//             issue stage can stall on outstanding long-latency destinations.
//
//  Ports    : clk, rst_n            clock, async active-low reset
//             iss_valid/iss_rd      long-latency issue, marks iss_rd pending
//             iss_ready             issue accepted (iss_rd not already pending)
//             a_valid/a_rd/a_data   ALU result, a_ready accepts it
//             b_valid/b_rd/b_data   long-latency result, b_ready accepts it
//             ra1, ra2              hazard query addresses
//             busy1, busy2          query address has a pending B write
//             fwd1_hit/fwd1_data    in-flight write matches ra1 (bypass build)
//             fwd2_hit/fwd2_data    in-flight write matches ra2 (bypass build)
//             we3, wa3, wd3         register file write port (registered)
//
//  Config   : REGFILE_WB_BYPASS_EN  when defined, the in-flight write is
//             exposed on fwd*, and busy* is released one cycle early for a
//             B write that is already on the write port.
//
//  Revision : 1.0  initial release
// ============================================================================
module regfile_writeback #(
   parameter int WIDTH      = 32,
   parameter int STARVE_MAX = 4      // 1..15
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             iss_valid,
   input  logic [4:0]       iss_rd,
   output logic             iss_ready,

   input  logic             a_valid,
   input  logic [4:0]       a_rd,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,

   input  logic             b_valid,
   input  logic [4:0]       b_rd,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,

   input  logic [4:0]       ra1,
   input  logic [4:0]       ra2,
   output logic             busy1,
   output logic             busy2,
   output logic             fwd1_hit,
   output logic             fwd2_hit,
   output logic [WIDTH-1:0] fwd1_data,
   output logic [WIDTH-1:0] fwd2_data,

   output logic             we3,
   output logic [4:0]       wa3,
   output logic [WIDTH-1:0] wd3
);

   localparam logic [3:0] C_STARVE_LIM = 4'(STARVE_MAX);
   localparam logic       C_SRC_A      = 1'b0;
   localparam logic       C_SRC_B      = 1'b1;

   // -------------------------------------------------------------------------
   // Arbitration
   // -------------------------------------------------------------------------
   logic [3:0] r_starve_cnt;
   logic       r_src;          // source of the write currently on we3/wa3/wd3
   logic       w_starve;
   logic       w_a_xfer;
   logic       w_b_xfer;

   assign w_starve = (r_starve_cnt == C_STARVE_LIM);

   // A has fixed priority until B has been blocked STARVE_MAX cycles in a
   // row. Then A is held off for exactly one cycle, which lets B through.
   // The two readies can never both produce a transfer in the same cycle.
   assign a_ready  = !w_starve;
   assign b_ready  = !a_valid || w_starve;

   assign w_a_xfer = a_valid && a_ready;
   assign w_b_xfer = b_valid && b_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= 4'd0;
      end else if (w_b_xfer) begin
         r_starve_cnt <= 4'd0;
      end else if (b_valid && !b_ready && (r_starve_cnt != C_STARVE_LIM)) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

   // -------------------------------------------------------------------------
   // Output register. It drives the register file write port straight from
   // flops, so no combinational path exists from a_*/b_* to we3/wa3/wd3.
   // A write to x0 still completes its handshake and loads wa3/wd3, but it
   // never raises we3.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we3   <= 1'b0;
         wa3   <= 5'd0;
         wd3   <= '0;
         r_src <= C_SRC_A;
      end else if (w_a_xfer) begin
         we3   <= (a_rd != 5'd0);
         wa3   <= a_rd;
         wd3   <= a_data;
         r_src <= C_SRC_A;
      end else if (w_b_xfer) begin
         we3   <= (b_rd != 5'd0);
         wa3   <= b_rd;
         wd3   <= b_data;
         r_src <= C_SRC_B;
      end else begin
         we3   <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Pending-write scoreboard. x0 is never pending, so only bits 31..1 exist
   // as flops. A bit is cleared at the same edge at which the register file
   // commits the B write to it. An issue to the same register in that cycle
   // takes precedence, so the new producer stays tracked.
   // -------------------------------------------------------------------------
   logic [31:1] r_busy;
   logic [31:0] w_busy;
   logic        w_set_en;
   logic        w_clr_en;

   assign w_busy    = {r_busy, 1'b0};
   assign iss_ready = !w_busy[iss_rd];
   assign w_set_en  = iss_valid && iss_ready && (iss_rd != 5'd0);
   assign w_clr_en  = we3 && (r_src == C_SRC_B);

   for (genvar i = 1; i < 32; i++) begin : g_sb
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_busy[i] <= 1'b0;
         end else if (w_set_en && (iss_rd == 5'(i))) begin
            r_busy[i] <= 1'b1;
         end else if (w_clr_en && (wa3 == 5'(i))) begin
            r_busy[i] <= 1'b0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Hazard query outputs
   // -------------------------------------------------------------------------
`ifdef REGFILE_WB_BYPASS_EN
   // The write on the port this cycle can be forwarded. A pending B
   // destination that is on the port right now no longer needs to stall.
   assign fwd1_hit  = we3 && (wa3 == ra1) && (ra1 != 5'd0);
   assign fwd2_hit  = we3 && (wa3 == ra2) && (ra2 != 5'd0);
   assign fwd1_data = wd3;
   assign fwd2_data = wd3;
   assign busy1     = w_busy[ra1] && !(fwd1_hit && (r_src == C_SRC_B));
   assign busy2     = w_busy[ra2] && !(fwd2_hit && (r_src == C_SRC_B));
`else
   assign fwd1_hit  = 1'b0;
   assign fwd2_hit  = 1'b0;
   assign fwd1_data = '0;
   assign fwd2_data = '0;
   assign busy1     = w_busy[ra1];
   assign busy2     = w_busy[ra2];
`endif

endmodule
`default_nettype wire
